// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST response analyzer
// and its signature-step helper.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

endpackage

// File: rtl/sig_lfsr_step.sv
// One Galois-form signature step: shifts in one response bit.
// Purely combinational, so a pattern generator can reuse it.
module sig_lfsr_step #(
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021
) (
    input  logic [SIG_W-1:0] sig,
    input  logic             din,
    output logic [SIG_W-1:0] sig_next
);

    logic fb;

    always_comb begin
        fb       = sig[SIG_W-1] ^ din;
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

endmodule

// File: rtl/bist_response_analyzer.sv
// Compacts a 1-bit response stream into a signature, counts vectors and ones,
// and compares against a golden signature when the programmed count is reached.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               CNT_W = 8,
    parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [SIG_W-1:0] golden_sig,
    input  logic             resp_valid,
    input  logic             resp_bit,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] ones_count
);

    // Handshake: a response transfers on a rising edge where resp_valid and
    // resp_ready are both 1; resp_ready never depends on resp_valid.

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    bist_state_t      state, state_next;
    logic [CNT_W-1:0] num_lat;
    logic [SIG_W-1:0] sig_next;
    logic             start_ok;
    logic             accept;
    logic             last_accept;

    sig_lfsr_step #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_step (
        .sig      (signature),
        .din      (resp_bit),
        .sig_next (sig_next)
    );

    always_comb begin
        start_ok    = start && (state != RUN);
        accept      = resp_valid && resp_ready;
        last_accept = accept && ((vec_count + CNT_ONE) == num_lat);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (num_vectors != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= SEED;
            vec_count  <= '0;
            ones_count <= '0;
            num_lat    <= '0;
        end else begin
            state      <= state_next;
            resp_ready <= (state_next == RUN);
            busy       <= (state_next == RUN);
            if (start_ok) begin
                num_lat    <= num_vectors;
                signature  <= SEED;
                vec_count  <= '0;
                ones_count <= '0;
                // A zero-vector session completes immediately against the seed.
                done       <= (num_vectors == '0);
                pass       <= (num_vectors == '0) && (SEED == golden_sig);
            end else if (accept) begin
                signature  <= sig_next;
                vec_count  <= vec_count + CNT_ONE;
                ones_count <= ones_count + CNT_W'(resp_bit);
                if (last_accept) begin
                    done <= 1'b1;
                    pass <= (sig_next == golden_sig);
                end
            end
        end
    end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench for bist_response_analyzer with a polynomial-division
// reference model and randomized response streams.
module tb_bist_response_analyzer;

    localparam int SIG_W = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic [SIG_W-1:0] golden_sig;
    logic             resp_valid;
    logic             resp_bit;
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] ones_count;

    int n_cmp;
    int n_fail;
    logic [SIG_W-1:0] exp_q[$];

    bist_response_analyzer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_vectors (num_vectors),
        .golden_sig  (golden_sig),
        .resp_valid  (resp_valid),
        .resp_bit    (resp_bit),
        .resp_ready  (resp_ready),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .vec_count   (vec_count),
        .ones_count  (ones_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signature as the remainder of a 17-bit polynomial division (x^16 + 0x1021).
    function automatic logic [15:0] model_sig(input logic bits[$]);
        logic [16:0] r;
        r = 17'h0FFFF;
        foreach (bits[i]) begin
            r = {r[15:0], 1'b0};
            if (r[16] ^ bits[i]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    function automatic int count_ones(input logic bits[$]);
        int c;
        c = 0;
        foreach (bits[i]) c += int'(bits[i]);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input int n, input logic [SIG_W-1:0] g, input logic v);
        start       = 1'b1;
        num_vectors = CNT_W'(n);
        golden_sig  = g;
        resp_valid  = v;
        tick();
        start       = 1'b0;
        resp_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; num_vectors = '0; golden_sig = '0;
        resp_valid = 1'b0; resp_bit = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({resp_ready, busy, done, pass, signature, vec_count, ones_count} !==
            {1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values got rdy=%b busy=%b done=%b pass=%b sig=%h vec=%0d ones=%0d",
                     resp_ready, busy, done, pass, signature, vec_count, ones_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        // resp_valid alongside start must not be accepted
        drive_start(1, 16'hEFDF, 1'b1);
        n_cmp++;
        if ({resp_ready, busy, done, vec_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL single_start got rdy=%b busy=%b done=%b vec=%0d want 1 1 0 0",
                     resp_ready, busy, done, vec_count);
        end
        resp_valid = 1'b1; resp_bit = 1'b0;
        tick();
        resp_valid = 1'b0;
        n_cmp++;
        if ({signature, vec_count, ones_count, done, pass, resp_ready} !==
            {16'hEFDF, 8'd1, 8'd0, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_done got sig=%h vec=%0d ones=%0d done=%b pass=%b rdy=%b want efdf 1 0 1 1 0",
                     signature, vec_count, ones_count, done, pass, resp_ready);
        end
    endtask

    task automatic test_two_ones();
        drive_start(2, 16'h0000, 1'b0);
        n_cmp++;
        if (done !== 1'b0 || pass !== 1'b0 || signature !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL two_restart got done=%b pass=%b sig=%h want 0 0 ffff", done, pass, signature);
        end
        resp_valid = 1'b1; resp_bit = 1'b1;
        tick();
        n_cmp++;
        if (signature !== 16'hFFFE || done !== 1'b0) begin
            n_fail++;
            $display("FAIL two_first got sig=%h done=%b want fffe 0", signature, done);
        end
        tick();
        resp_valid = 1'b0;
        n_cmp++;
        if ({signature, ones_count, vec_count, done, pass} !== {16'hFFFC, 8'd2, 8'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL two_final got sig=%h ones=%0d vec=%0d done=%b pass=%b want fffc 2 2 1 0",
                     signature, ones_count, vec_count, done, pass);
        end
    endtask

    task automatic test_gaps();
        logic bits[$];
        logic sofar[$];
        logic [SIG_W-1:0] gold;
        logic [SIG_W-1:0] hold_sig;
        int acc, cyc;
        logic v;
        for (int i = 0; i < 60; i++) bits.push_back(1'($urandom_range(0, 1)));
        gold = model_sig(bits);
        drive_start(60, gold, 1'b0);
        acc = 0; cyc = 0;
        while (acc < 60 && cyc < 1000) begin
            v = ($urandom_range(0, 2) != 0);
            resp_valid = v;
            resp_bit   = bits[acc];
            n_cmp++;
            if (resp_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL gaps_ready cyc=%0d got %b want 1", cyc, resp_ready);
            end
            if (v) begin
                sofar.push_back(bits[acc]);
                exp_q.push_back(model_sig(sofar));
                acc++;
            end
            tick();
            cyc++;
            if (v) begin
                n_cmp++;
                if (signature !== exp_q[0] || vec_count !== CNT_W'(acc)) begin
                    n_fail++;
                    $display("FAIL gaps_step acc=%0d got sig=%h vec=%0d want %h %0d",
                             acc, signature, vec_count, exp_q[0], acc);
                end
                void'(exp_q.pop_front());
            end
        end
        resp_valid = 1'b0;
        n_cmp++;
        if (acc != 60) begin
            n_fail++;
            $display("FAIL gaps_budget got %0d accepts want 60", acc);
        end
        n_cmp++;
        if ({resp_ready, busy, done, pass, signature, vec_count, ones_count} !==
            {1'b0, 1'b0, 1'b1, 1'b1, gold, 8'd60, CNT_W'(count_ones(bits))}) begin
            n_fail++;
            $display("FAIL gaps_final got rdy=%b busy=%b done=%b pass=%b sig=%h vec=%0d ones=%0d want 0 0 1 1 %h 60 %0d",
                     resp_ready, busy, done, pass, signature, vec_count, ones_count, gold, count_ones(bits));
        end
        hold_sig = gold;
        for (int i = 0; i < 5; i++) begin
            resp_valid = 1'b1;
            resp_bit   = 1'($urandom_range(0, 1));
            tick();
        end
        resp_valid = 1'b0;
        n_cmp++;
        if ({signature, vec_count, done, pass, resp_ready} !== {hold_sig, 8'd60, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL gaps_after_done got sig=%h vec=%0d done=%b pass=%b rdy=%b",
                     signature, vec_count, done, pass, resp_ready);
        end
    endtask

    task automatic test_zero();
        drive_start(0, 16'hFFFF, 1'b0);
        n_cmp++;
        if ({done, pass, resp_ready, busy, signature, vec_count} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 8'd0}) begin
            n_fail++;
            $display("FAIL zero_done got done=%b pass=%b rdy=%b busy=%b sig=%h vec=%0d want 1 1 0 0 ffff 0",
                     done, pass, resp_ready, busy, signature, vec_count);
        end
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1; resp_bit = 1'b1;
            n_cmp++;
            if (resp_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_ready cyc=%0d got %b want 0", i, resp_ready);
            end
            tick();
        end
        resp_valid = 1'b0;
        n_cmp++;
        if (vec_count !== 8'd0 || ones_count !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_counts got vec=%0d ones=%0d want 0 0", vec_count, ones_count);
        end
    endtask

    task automatic test_reset_mid_run();
        logic bits[$];
        logic [SIG_W-1:0] gold;
        drive_start(20, 16'h1234, 1'b0);
        for (int i = 0; i < 10; i++) begin
            resp_valid = 1'b1; resp_bit = 1'($urandom_range(0, 1));
            tick();
        end
        resp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({signature, vec_count, ones_count, resp_ready, busy, done} !==
            {16'hFFFF, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got sig=%h vec=%0d ones=%0d rdy=%b busy=%b done=%b",
                     signature, vec_count, ones_count, resp_ready, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (resp_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got rdy=%b busy=%b want 0 0", resp_ready, busy);
        end
        for (int i = 0; i < 3; i++) bits.push_back(1'($urandom_range(0, 1)));
        gold = model_sig(bits);
        drive_start(3, gold, 1'b0);
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1; resp_bit = bits[i];
            // start mid-RUN must neither restart nor change the count
            if (i == 1) begin
                start = 1'b1; num_vectors = 8'd5;
            end
            tick();
            start = 1'b0;
        end
        resp_valid = 1'b0;
        n_cmp++;
        if ({done, pass, signature, vec_count, ones_count, resp_ready} !==
            {1'b1, 1'b1, gold, 8'd3, CNT_W'(count_ones(bits)), 1'b0}) begin
            n_fail++;
            $display("FAIL short_session got done=%b pass=%b sig=%h vec=%0d ones=%0d rdy=%b want 1 1 %h 3 %0d 0",
                     done, pass, signature, vec_count, ones_count, resp_ready, gold, count_ones(bits));
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_two_ones();
        test_gaps();
        test_zero();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bist_response_analyzer.md
# bist_response_analyzer

Response-side companion to the combinational stimulus bench. Each cycle it accepts one 1-bit DUT response (`out_signal`) per applied test vector, compacts the response stream into a CRC-style signature, and counts vectors and ones. After a programmed number of vectors it compares the signature against a golden value and reports pass or fail. It sits between the DUT output and the self-checking logic of the bench or BIST wrapper.

## Interface
Parameters:
- `SIG_W`, 16: signature width.
- `CNT_W`, 8: vector and ones counter width.
- `POLY`, 16'h1021: feedback polynomial (Galois form, x^SIG_W implicit).
- `SEED`, 16'hFFFF: signature initial value.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a session.
- `num_vectors`  in  CNT_W  vectors per session; sampled when `start` is accepted.
- `golden_sig`  in  SIG_W  expected signature; sampled at completion.
- `resp_valid`  in  1  `resp_bit` is valid.
- `resp_bit`  in  1  DUT response bit.
- `resp_ready`  out  1  analyzer accepts a response this cycle.
- `busy`  out  1  session in progress.
- `done`  out  1  session complete; held until the next accepted `start`.
- `pass`  out  1  signature matched `golden_sig`; meaningful only while `done`=1.
- `signature`  out  SIG_W  current signature register.
- `vec_count`  out  CNT_W  responses accepted this session.
- `ones_count`  out  CNT_W  accepted responses equal to 1.

## Operation
- States: IDLE, RUN, DONE.
- Reset value of every output: `signature`=SEED; all other outputs 0. State is IDLE.
- IDLE/DONE with `start`=1: latch `num_vectors`, set `signature`=SEED, clear both counters, `done`, and `pass`.
  - If latched count is nonzero, go to RUN.
  - If it is 0, go to DONE.
- `start` in RUN is ignored.
- RUN: `resp_ready`=1 and `busy`=1. A response is accepted when `resp_valid && resp_ready`. On accept:
  - fb = `signature[SIG_W-1] ^ resp_bit`
  - `signature` <= {`signature[SIG_W-2:0]`,0} ^ (fb ? POLY : 0)
  - `vec_count` += 1
  - `ones_count` += `resp_bit`
- Cycles with no accepted response change nothing.
- When the accept brings `vec_count` to the latched count, go to DONE with `done`=1 and `pass` = (updated signature == `golden_sig`), both in the same edge.
- Zero-vector session: DONE with `pass` = (SEED == `golden_sig`).
- `resp_valid` outside RUN is ignored. `resp_ready`=0 in IDLE and DONE.
- Counters cannot overflow, because `ones_count` ≤ `vec_count` ≤ `num_vectors` ≤ 2^CNT_W−1.
- Changing `num_vectors` mid-session has no effect.

## Timing
- `resp_ready` is a registered decode of state. It is 1 from the cycle after `start` (nonzero count) through the cycle of the final accept. It is 0 the following cycle.
- Throughput: one response per cycle.
- `done`, `pass`, `signature`, and the counters update on the final-accept edge. There is no extra latency.
- `start` and `resp_valid` in the same IDLE cycle: the response is not accepted.
- `rst_n` low at any time, including mid-RUN: outputs take their reset values immediately. The session is lost. `start` is needed after release.

## Structure
- Package `bist_pkg` holds:
  - state enum `bist_state_t` {IDLE, RUN, DONE}
  - default `POLY`/`SEED` constants
- Sub-module `sig_lfsr_step` is natural: a combinational next-signature function of (sig, bit), reusable by a future pattern-generator block.
- FSM, counters, and compare live in the top.

## Test plan
- Reset, then `num_vectors`=1, `resp_bit`=0 → `signature`=16'hEFDF, `vec_count`=1, `ones_count`=0. With `golden_sig`=16'hEFDF: `done`=1, `pass`=1.
- `num_vectors`=2, bits 1,1 → signature after first bit 16'hFFFE, final 16'hFFFC, `ones_count`=2. With `golden_sig`=16'h0000: `pass`=0.
- `num_vectors`=60 with random `resp_valid` gaps → exactly 60 accepts, and `resp_ready` falls the cycle after the 60th. Signature matches the reference model. `resp_valid` pulses after `done` leave everything unchanged.
- `num_vectors`=0, `golden_sig`=16'hFFFF → DONE one cycle after `start`, `pass`=1, `resp_ready` never asserted.
- `rst_n` pulsed low after 10 of 20 vectors → outputs reset immediately (`signature`=16'hFFFF, counts 0). A new `start` with a 3-vector session completes correctly. `start` issued mid-RUN is ignored.
